weight_bit_serializer: RTL and testbench

- Transmit-side feeder for the bit-serial MAC datapath.
- Accepts parallel weight words over a valid/ready handshake and drives them out LSB-first, one bit per cycle.
- Flags the first bit and the last (sign) bit of each word, at the word's selected precision of 8, 4 or 2 bits.
- Sits between the weight buffer and the MAC's serial weight input. Two-entry buffering (hold register + shift register) lets consecutive words stream with no bubbles.

---
 rtl/weight_bit_serializer_if.sv | 27 ++
 rtl/weight_bit_serializer.sv | 156 +++++++++++++++
 tb/tb_weight_bit_serializer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/weight_bit_serializer_if.sv
// Parallel-in / serial-out bus bundle for the weight serializer.
// master = weight buffer + MAC side; slave = the serializer itself.
interface weight_bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
);
    logic [WIDTH-1:0] w_data;
    logic [1:0]       w_prec;
    logic             w_valid;
    logic             w_ready;
    logic             s_bit;
    logic             s_valid;
    logic             s_ready;
    logic             s_first;
    logic             s_last;
    logic [IDXW-1:0]  s_idx;

    modport master (
        output w_data, w_prec, w_valid, s_ready,
        input  w_ready, s_bit, s_valid, s_first, s_last, s_idx
    );

    modport slave (
        input  w_data, w_prec, w_valid, s_ready,
        output w_ready, s_bit, s_valid, s_first, s_last, s_idx
    );
endinterface

// File: rtl/weight_bit_serializer.sv
// Weight serializer: parallel two's-complement words in, LSB-first bits out with first/sign flags.
// Latency: bit 0 valid the cycle after acceptance; s_valid & !s_ready freezes the outputs; w_ready = !hold_full.
module weight_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    output logic                    busy,
    weight_bit_serializer_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sh_word;
    logic [IDXW-1:0]   sh_idx;
    logic [IDXW-1:0]   sh_lastidx;
    logic              first_q;
    logic              last_q;
    logic [WIDTH-1:0]  hd_word;
    logic [IDXW-1:0]   hd_lastidx;
    logic              hd_full;

    logic              fire;
    logic              at_last;
    logic              accept;
    logic              ld_in;
    logic              ld_hd;
    logic              adv;
    logic              to_hd;
    logic              drain;

    // Precision is kept as the index of the sign bit, so end-of-word is a single compare.
    function automatic logic [IDXW-1:0] last_index(input logic [1:0] prec);
        case (prec)
            2'b00:   return IDXW'(WIDTH - 1);
            2'b10:   return IDXW'(1);
            default: return IDXW'(3);
        endcase
    endfunction

    assign bus.w_ready = !hd_full;
    assign bus.s_valid = (state == SHIFT);
    assign bus.s_bit   = sh_word[0];
    assign bus.s_idx   = sh_idx;
    assign bus.s_first = first_q;
    assign bus.s_last  = last_q;
    assign busy        = (state == SHIFT) | hd_full;

    assign fire    = bus.s_valid & bus.s_ready;
    assign at_last = (sh_idx == sh_lastidx);
    assign accept  = bus.w_valid & !hd_full & !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_in     = 1'b0;
        ld_hd     = 1'b0;
        adv       = 1'b0;
        to_hd     = 1'b0;
        drain     = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ld_in     = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (fire && !at_last) begin
                        adv = 1'b1;
                    end else if (fire) begin
                        // Word done: hold entry has priority over a fresh word.
                        if (hd_full) begin
                            ld_hd = 1'b1;
                        end else if (accept) begin
                            ld_in = 1'b1;
                        end else begin
                            drain     = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    if (accept && !ld_in) begin
                        to_hd = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_word    <= '0;
            sh_idx     <= '0;
            sh_lastidx <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            hd_word    <= '0;
            hd_lastidx <= '0;
            hd_full    <= 1'b0;
        end else if (flush) begin
            sh_word <= '0;
            sh_idx  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            hd_full <= 1'b0;
        end else begin
            if (ld_in) begin
                sh_word    <= bus.w_data;
                sh_idx     <= '0;
                sh_lastidx <= last_index(bus.w_prec);
                first_q    <= 1'b1;
                last_q     <= (last_index(bus.w_prec) == '0);
            end else if (ld_hd) begin
                sh_word    <= hd_word;
                sh_idx     <= '0;
                sh_lastidx <= hd_lastidx;
                first_q    <= 1'b1;
                last_q     <= (hd_lastidx == '0);
            end else if (adv) begin
                // Shift right so the current bit is always a flop output at bit 0.
                sh_word <= sh_word >> 1;
                sh_idx  <= sh_idx + IDXW'(1);
                first_q <= 1'b0;
                last_q  <= ((sh_idx + IDXW'(1)) == sh_lastidx);
            end else if (drain) begin
                sh_word <= '0;
                sh_idx  <= '0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end

            if (to_hd) begin
                hd_word    <= bus.w_data;
                hd_lastidx <= last_index(bus.w_prec);
                hd_full    <= 1'b1;
            end else if (ld_hd) begin
                hd_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed bench for weight_bit_serializer: framing, back-to-back, precision, stall, flush, async reset.
module tb_weight_bit_serializer;

    logic clk = 1'b0;
    logic rstn;
    logic flush;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  wa, wb;
    logic [15:0] stream;
    logic        eb;

    weight_bit_serializer_if #(.WIDTH(8), .IDXW(3)) bus ();

    weight_bit_serializer #(.WIDTH(8), .IDXW(3)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic b,
                           input logic f, input logic l, input logic [2:0] idx);
        chk({tag, "_valid"}, bus.s_valid, v);
        chk({tag, "_bit"},   bus.s_bit,   b);
        chk({tag, "_first"}, bus.s_first, f);
        chk({tag, "_last"},  bus.s_last,  l);
        chk({tag, "_idx"},   bus.s_idx,   idx);
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        bus.w_data  = '0;
        bus.w_prec  = 2'b00;
        bus.w_valid = 1'b0;
        bus.s_ready = 1'b1;
        tick();
        tick();
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wready", bus.w_ready, 1'b1);
        rstn = 1'b1;
        tick();

        // 1: single 8-bit word 0x09
        wa = 8'h09;
        bus.w_data = wa; bus.w_prec = 2'b00; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out("t1", 1'b1, wa[i], i == 0, i == 7, 3'(i));
            tick();
        end
        chk("t1_end_valid", bus.s_valid, 1'b0);
        chk("t1_end_busy", busy, 1'b0);

        // 2: back-to-back 0x55, 0xAA
        stream = 16'hAA55;
        bus.w_data = 8'h55; bus.w_prec = 2'b00; bus.w_valid = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            eb = stream[i];
            chk("t2_valid", bus.s_valid, 1'b1);
            chk("t2_bit", bus.s_bit, eb);
            chk("t2_wready", bus.w_ready, (i == 0) || (i >= 8));
            chk("t2_last", bus.s_last, (i == 7) || (i == 15));
            if (i == 0) begin
                bus.w_data = 8'hAA; bus.w_valid = 1'b1;
            end
            tick();
            if (i == 0) bus.w_valid = 1'b0;
        end
        chk("t2_end_valid", bus.s_valid, 1'b0);

        // 3: 0xD8 at 4 bits then at 2 bits; w_prec changed after acceptance
        wa = 8'hD8; wb = 8'hD8;
        bus.w_data = wa; bus.w_prec = 2'b01; bus.w_valid = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            eb = (i < 4) ? wa[i] : wb[i - 4];
            chk_out("t3", 1'b1, eb, (i == 0) || (i == 4), (i == 3) || (i == 5),
                    (i < 4) ? 3'(i) : 3'(i - 4));
            chk("t3_wready", bus.w_ready, (i == 0) || (i >= 4));
            if (i == 0) begin
                bus.w_data = wb; bus.w_prec = 2'b10; bus.w_valid = 1'b1;
            end
            tick();
            if (i == 0) begin
                bus.w_valid = 1'b0; bus.w_prec = 2'b00;
            end
        end
        chk("t3_end_valid", bus.s_valid, 1'b0);

        // 4: stall 3 cycles at idx 2 of 0x0B
        wa = 8'h0B;
        bus.w_data = wa; bus.w_prec = 2'b00; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                bus.s_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk_out("t4_stall", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
                    tick();
                end
                bus.s_ready = 1'b1;
            end
            chk_out("t4", 1'b1, wa[i], i == 0, i == 7, 3'(i));
            tick();
        end
        chk("t4_end_valid", bus.s_valid, 1'b0);

        // 5: flush at idx 4 with hold entry full
        bus.w_data = 8'hF0; bus.w_prec = 2'b00; bus.w_valid = 1'b1;
        tick();
        bus.w_data = 8'h33;
        tick();
        bus.w_valid = 1'b0;
        tick(); tick(); tick();
        chk("t5_pre_idx", bus.s_idx, 3'd4);
        chk("t5_pre_wready", bus.w_ready, 1'b0);
        flush = 1'b1; bus.w_data = 8'hFF; bus.w_valid = 1'b1;
        tick();
        flush = 1'b0; bus.w_valid = 1'b0;
        chk("t5_valid", bus.s_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_wready", bus.w_ready, 1'b1);
        tick();
        chk("t5_idle_valid", bus.s_valid, 1'b0);
        wa = 8'h06;
        bus.w_data = wa; bus.w_prec = 2'b10; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        chk_out("t5_b0", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        chk_out("t5_b1", 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        chk("t5_end_valid", bus.s_valid, 1'b0);

        // 6: asynchronous reset while a sign bit is on the output
        bus.w_data = 8'h03; bus.w_prec = 2'b10; bus.w_valid = 1'b1;
        tick();
        bus.w_data = 8'h81; bus.w_prec = 2'b00;
        tick();
        bus.w_valid = 1'b0;
        chk("t6_pre_last", bus.s_last, 1'b1);
        chk("t6_pre_busy", busy, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_valid", bus.s_valid, 1'b0);
        chk("t6_last", bus.s_last, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_wready", bus.w_ready, 1'b1);
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_idle_valid", bus.s_valid, 1'b0);
        bus.w_data = 8'hFF; bus.w_prec = 2'b10; bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        chk_out("t6_b0", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        chk_out("t6_b1", 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        chk("t6_end_valid", bus.s_valid, 1'b0);
        chk("t6_end_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
